// File: rtl/fifo_stream_reader.sv
// Read-side FIFO drain engine: pops under a credit limit, realigns data returning
// after the fixed read latency, and streams it out through a skid buffer.
module fifo_stream_reader #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned RD_LATENCY = 2,
  parameter int unsigned SKID_DEPTH = 4,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  rclk,
  input  logic                  rrst,
  input  logic                  enable,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  idle,
  output logic [CNT_WIDTH-1:0]  words_out
);

  localparam int unsigned IDX_W = $clog2(SKID_DEPTH);
  localparam int unsigned PTR_W = IDX_W + 1;
  localparam int unsigned CRD_W = $clog2(SKID_DEPTH + RD_LATENCY + 1);

  logic [RD_LATENCY-1:0] pipe;
  logic [DATA_WIDTH-1:0] mem [SKID_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      occ;
  logic [CRD_W-1:0]      inflight;
  logic [CRD_W-1:0]      credits;
  logic                  land;
  logic                  take;
  logic                  full;

  // Occupancy and credit accounting from registered state only.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < int'(RD_LATENCY); i++) begin
      inflight = inflight + CRD_W'(pipe[i]);
    end
    occ     = wr_ptr - rd_ptr;
    credits = CRD_W'(occ) + inflight;
    full    = (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]) && (wr_ptr[IDX_W] != rd_ptr[IDX_W]);
    land    = pipe[RD_LATENCY-1];
  end

  // Pop only when the landing word is guaranteed a skid slot.
  always_comb begin
    fifo_rd_en = !rrst && enable && !fifo_empty && (credits < CRD_W'(SKID_DEPTH));
    m_valid    = (occ != '0);
    m_data     = mem[rd_ptr[IDX_W-1:0]];
    idle       = (occ == '0) && (inflight == '0);
    take       = m_valid && m_ready;
  end

  always_ff @(posedge rclk) begin
    if (rrst) begin
      pipe      <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      words_out <= '0;
      for (int i = 0; i < int'(SKID_DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else begin
      pipe[0] <= fifo_rd_en;
      for (int i = 1; i < int'(RD_LATENCY); i++) begin
        pipe[i] <= pipe[i-1];
      end
      // Last pipe stage marks the cycle the FIFO word is on fifo_rd_data.
      if (land) begin
        mem[wr_ptr[IDX_W-1:0]] <= fifo_rd_data;
        wr_ptr                 <= wr_ptr + PTR_W'(1);
      end
      if (take) begin
        rd_ptr    <= rd_ptr + PTR_W'(1);
        words_out <= words_out + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: FIFO environment plus a queue-based reference of
// popped words and their landing cycles, compared against the DUT every cycle.
module tb_fifo_stream_reader;

  localparam int unsigned DW = 8;
  localparam int unsigned L  = 2;
  localparam int unsigned D  = 4;
  localparam int unsigned CW = 4;

  logic          rclk = 1'b0;
  logic          rrst;
  logic          enable;
  logic          fifo_empty;
  logic          fifo_rd_en;
  logic [DW-1:0] fifo_rd_data;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          idle;
  logic [CW-1:0] words_out;

  fifo_stream_reader #(
    .DATA_WIDTH(DW), .RD_LATENCY(L), .SKID_DEPTH(D), .CNT_WIDTH(CW)
  ) dut (
    .rclk(rclk), .rrst(rrst), .enable(enable), .fifo_empty(fifo_empty),
    .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data), .m_valid(m_valid),
    .m_ready(m_ready), .m_data(m_data), .idle(idle), .words_out(words_out)
  );

  always #5 rclk = ~rclk;

  int checks = 0;
  int passed = 0;
  int cyc    = 0;

  bit rst_v, en_v, rdy_v, hold_empty;
  logic [DW-1:0] fifo_q[$];
  int            m_land[$];
  logic [DW-1:0] m_word[$];
  int            words_exp;
  logic [DW-1:0] slot[8];
  bit            slot_v[8];
  bit            h_rden[4096];
  bit            h_valid[4096];
  logic [DW-1:0] h_data[4096];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
  endtask

  function automatic int cnt_rden(input int from, input int n);
    int s = 0;
    for (int i = 0; i < n; i++) s += int'(h_rden[from+i]);
    return s;
  endfunction

  function automatic int cnt_valid(input int from, input int n);
    int s = 0;
    for (int i = 0; i < n; i++) s += int'(h_valid[from+i]);
    return s;
  endfunction

  // One clock: drive inputs, compare at negedge, advance model and FIFO at posedge.
  task automatic step();
    int occ, infl;
    bit e_rden, e_valid, rden_s;
    logic [DW-1:0] e_data;
    rrst         = rst_v;
    enable       = en_v;
    m_ready      = rdy_v;
    fifo_empty   = hold_empty || (fifo_q.size() == 0);
    fifo_rd_data = slot_v[cyc%8] ? slot[cyc%8] : DW'($urandom);
    slot_v[cyc%8] = 1'b0;
    @(negedge rclk);
    occ  = 0;
    infl = 0;
    foreach (m_land[i]) begin
      if (m_land[i] <= cyc) occ++;
      else infl++;
    end
    e_valid = (occ != 0);
    e_data  = e_valid ? m_word[0] : '0;
    e_rden  = !rrst && enable && !fifo_empty && (occ + infl < int'(D));
    chk("fifo_rd_en", fifo_rd_en, e_rden);
    chk("m_valid", m_valid, e_valid);
    if (e_valid) chk("m_data", m_data, e_data);
    chk("idle", idle, (occ == 0) && (infl == 0));
    chk("words_out", words_out, words_exp);
    if (dut.land) chk("land_into_full", dut.full, 0);
    if (cyc < 4096) begin
      h_rden[cyc]  = fifo_rd_en;
      h_valid[cyc] = m_valid;
      h_data[cyc]  = m_data;
    end
    rden_s = fifo_rd_en;
    @(posedge rclk);
    if (rrst) begin
      m_land.delete();
      m_word.delete();
      words_exp = 0;
    end else begin
      if (e_valid && m_ready) begin
        void'(m_land.pop_front());
        void'(m_word.pop_front());
        words_exp = (words_exp + 1) % (1 << CW);
      end
      if (e_rden && fifo_q.size() > 0) begin
        m_land.push_back(cyc + int'(L) + 1);
        m_word.push_back(fifo_q[0]);
      end
    end
    if (rden_s && fifo_q.size() > 0) begin
      slot[(cyc+int'(L))%8]   = fifo_q.pop_front();
      slot_v[(cyc+int'(L))%8] = 1'b1;
    end
    cyc++;
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  initial begin
    int a, b, c, e, r, f;
    rst_v = 1; en_v = 0; rdy_v = 0; hold_empty = 0; words_exp = 0;
    rrst = 1; enable = 0; m_ready = 0; fifo_empty = 1; fifo_rd_data = '0;
    @(posedge rclk); #1;
    run(2);
    rst_v = 0;
    chk("rst_rd_en", fifo_rd_en, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_idle", idle, 1);
    chk("rst_words_out", words_out, 0);

    // Basic drain of three words
    fifo_q = '{8'h11, 8'h22, 8'h33};
    en_v = 1; rdy_v = 1;
    a = cyc;
    run(8);
    chk("drain_pops", cnt_rden(a, 8), 3);
    chk("drain_pop_run", cnt_rden(a, 3), 3);
    chk("drain_not_yet", h_valid[a+2], 0);
    chk("drain_w0", h_data[a+3], 8'h11);
    chk("drain_w1", h_data[a+4], 8'h22);
    chk("drain_w2", h_data[a+5], 8'h33);
    chk("drain_valid_run", cnt_valid(a+3, 3), 3);
    chk("drain_after", h_valid[a+6], 0);
    chk("drain_count", words_out, 3);
    chk("drain_idle", idle, 1);

    // Streaming throughput
    for (int i = 0; i < 16; i++) fifo_q.push_back(DW'(8'h40 + i));
    b = cyc;
    run(22);
    chk("stream_pops", cnt_rden(b, 16), 16);
    chk("stream_valid_run", cnt_valid(b+3, 16), 16);
    chk("stream_last", h_data[b+18], 8'h4f);
    chk("stream_end", h_valid[b+19], 0);

    // Backpressure
    for (int i = 0; i < 8; i++) fifo_q.push_back(DW'(8'ha0 + i));
    rdy_v = 0;
    c = cyc;
    run(10);
    chk("bp_pops", cnt_rden(c, 10), 4);
    chk("bp_first", h_data[c+3], 8'ha0);
    chk("bp_hold_data", h_data[c+9], 8'ha0);
    chk("bp_hold_valid", h_valid[c+9], 1);
    rdy_v = 1;
    run(14);
    chk("bp_idle", idle, 1);

    // Empty gap mid-stream
    for (int i = 0; i < 6; i++) fifo_q.push_back(DW'(8'hb0 + i));
    run(2);
    hold_empty = 1;
    e = cyc;
    run(5);
    chk("gap_no_pops", cnt_rden(e, 5), 0);
    chk("gap_valid_drops", h_valid[e+4], 0);
    hold_empty = 0;
    run(12);
    chk("gap_idle", idle, 1);

    // Reset with words buffered and in flight
    for (int i = 0; i < 4; i++) fifo_q.push_back(DW'(8'hc0 + i));
    rdy_v = 0;
    r = cyc;
    run(5);
    chk("rf_pops", cnt_rden(r, 5), 4);
    chk("rf_buffered", m_valid, 1);
    rst_v = 1; en_v = 0;
    run(1);
    rst_v = 0; rdy_v = 1;
    chk("rf_m_valid", m_valid, 0);
    chk("rf_idle", idle, 1);
    chk("rf_words_out", words_out, 0);
    r = cyc;
    run(6);
    chk("rf_nothing_late", cnt_valid(r, 6), 0);

    // Counter wrap at 4 bits
    for (int i = 0; i < 17; i++) fifo_q.push_back(DW'(8'hd0 + i));
    en_v = 1;
    run(24);
    chk("wrap_words_out", words_out, 1);
    chk("wrap_idle", idle, 1);

    // Enable drop with two pops in flight
    for (int i = 0; i < 4; i++) fifo_q.push_back(DW'(8'he0 + i));
    run(2);
    en_v = 0;
    f = cyc;
    run(6);
    chk("en_no_pops", cnt_rden(f, 6), 0);
    chk("en_delivered", words_out, 3);
    chk("en_idle", idle, 1);
    chk("en_fifo_left", fifo_q.size(), 2);

    // Randomized traffic
    fifo_q.delete();
    for (int k = 0; k < 900; k++) begin
      rst_v      = ($urandom_range(0, 199) == 0);
      en_v       = ($urandom_range(0, 9) != 0);
      rdy_v      = ($urandom_range(0, 9) < 7);
      hold_empty = ($urandom_range(0, 9) < 2);
      if ($urandom_range(0, 2) != 0 && fifo_q.size() < 32) fifo_q.push_back(DW'($urandom));
      step();
    end
    rst_v = 0; en_v = 0; rdy_v = 1; hold_empty = 0;
    run(12);
    chk("final_idle", idle, 1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
